fetch_unit: RTL

Instruction fetch stage between the program ROM and the decoder. Owns the program counter, drives the ROM's combinational byte-address input, and captures the returned 32-bit word together with its PC into a 2-entry fetch buffer. Delivers instructions to decode over a valid/ready handshake and accepts PC redirects from the branch/jump unit, which flush the buffer.

---
 rtl/fetch_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational program ROM and
// queues {word, pc} pairs in a 2-entry buffer for decode. Optional PC range check: FETCH_BOUND_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif

  localparam logic [31:0] RESET_PC_AL = align4(RESET_PC);
  localparam logic [32:0] PC_LIMIT    = 33'(ROM_WORDS) << 2;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_word [2];
  logic [31:0] r_pc   [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic        r_fault;

  logic        w_pop;
  logic        w_oob;
  logic        w_cap;

  assign w_pop = inst_valid && inst_ready;
  assign w_oob = BOUND_EN && ({1'b0, r_fetch_pc} >= PC_LIMIT);
  // Pop frees a slot in the same cycle, so a full buffer can still capture.
  assign w_cap = !redirect && !w_oob && ((r_count != 2'd2) || w_pop);

  assign rom_addr    = r_fetch_pc;
  assign inst_valid  = (r_count != 2'd0);
  assign inst        = r_word[r_rd_ptr];
  assign inst_pc     = r_pc[r_rd_ptr];
  assign fetch_fault = BOUND_EN ? r_fault : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC_AL;
      r_word[0]  <= '0;
      r_word[1]  <= '0;
      r_pc[0]    <= '0;
      r_pc[1]    <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_fault    <= 1'b0;
    end else if (redirect) begin
      // Any concurrent pop is implicitly honoured: every entry is dropped anyway.
      r_fetch_pc <= align4(redirect_pc);
      r_rd_ptr   <= r_wr_ptr;
      r_count    <= 2'd0;
      r_fault    <= 1'b0;
    end else begin
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      if (w_cap) begin
        r_word[r_wr_ptr] <= rom_data;
        r_pc[r_wr_ptr]   <= r_fetch_pc;
        r_wr_ptr         <= ~r_wr_ptr;
        r_fetch_pc       <= r_fetch_pc + 32'd4;
      end
      if (w_oob) r_fault <= 1'b1;
      r_count <= r_count + {1'b0, w_cap} - {1'b0, w_pop};
    end
  end

endmodule
